// File: rtl/fpu_mds_issue_if.sv
`default_nettype none
// ============================================================================
// Module   : fpu_mds_issue_if
// Purpose  : Bundles the request channel, the multiply/divide/sqrt unit
//            start/done handshake and the writeback response channel used
//            by fpu_mds_issue.
// Modports : slave  - the issue sequencer (fpu_mds_issue)
//            master - the surrounding pipeline, unit and writeback
// Signals  : req_*  request from the FPU pipeline stage (valid/ready)
//            mds_*  operands, op, rounding mode, start and unit results
//            resp_* captured response to writeback (valid/ready)
//            busy   sequencer is not idle
// Revision : 1.0 - initial release
// ============================================================================
interface fpu_mds_issue_if #(
   parameter int TAG_W = 5
);
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_op;
   logic [2:0]       req_rm;
   logic [31:0]      req_a;
   logic [31:0]      req_b;
   logic [TAG_W-1:0] req_tag;

   logic             mds_start;
   logic [1:0]       mds_op;
   logic [2:0]       mds_rm;
   logic [31:0]      mds_a;
   logic [31:0]      mds_b;
   logic             mds_done;
   logic [31:0]      mds_out;
   logic             mds_overflow;
   logic             mds_underflow;
   logic             mds_invalid;
   logic             mds_inexact;
   logic             mds_div_by_zero;

   logic             resp_valid;
   logic             resp_ready;
   logic [31:0]      resp_result;
   logic [4:0]       resp_flags;
   logic [TAG_W-1:0] resp_tag;
   logic             resp_timeout;

   logic             busy;

   modport slave (
      input  req_valid, req_op, req_rm, req_a, req_b, req_tag,
      input  mds_done, mds_out, mds_overflow, mds_underflow, mds_invalid,
             mds_inexact, mds_div_by_zero,
      input  resp_ready,
      output req_ready,
      output mds_start, mds_op, mds_rm, mds_a, mds_b,
      output resp_valid, resp_result, resp_flags, resp_tag, resp_timeout,
      output busy
   );

   modport master (
      output req_valid, req_op, req_rm, req_a, req_b, req_tag,
      output mds_done, mds_out, mds_overflow, mds_underflow, mds_invalid,
             mds_inexact, mds_div_by_zero,
      output resp_ready,
      input  req_ready,
      input  mds_start, mds_op, mds_rm, mds_a, mds_b,
      input  resp_valid, resp_result, resp_flags, resp_tag, resp_timeout,
      input  busy
   );
endinterface
`default_nettype wire

// File: rtl/fpu_mds_issue.sv
`default_nettype none
// ============================================================================
// Module   : fpu_mds_issue
// Purpose  : Issue/response sequencer for the FPU multiply/divide/sqrt unit.
//            Accepts one FMUL/FDIV/FSQRT request, holds op/rm/operands on the
//            unit inputs, pulses start, waits for done, captures the result
//            and exception flags and offers them to writeback. One operation
//            in flight at a time.
// Ports    : clk   - clock
//            reset - synchronous active-high reset
//            bus   - fpu_mds_issue_if.slave (request, unit, response, busy)
// Params   : TAG_W          - destination tag width
//            TIMEOUT_CYCLES - watchdog limit in ISSUE/BUSY
// Macro    : FPU_MDS_TIMEOUT_EN - compiles in the BUSY watchdog; without it
//            resp_timeout is tied low and BUSY waits indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_mds_issue #(
   parameter int TAG_W          = 5,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  wire logic       clk,
   input  wire logic       reset,
   fpu_mds_issue_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_BUSY  = 2'd2,
      S_RESP  = 2'd3
   } state_e;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_e           state_q, state_d;
   logic [1:0]       op_q;
   logic [2:0]       rm_q;
   logic [31:0]      a_q, b_q;
   logic [TAG_W-1:0] tag_q;
   logic [31:0]      result_q, result_d;
   logic [4:0]       flags_q, flags_d;
   logic             load;

`ifdef FPU_MDS_TIMEOUT_EN
   localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0]  C_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] cnt_q;
   logic             timeout_q, timeout_d;
`endif

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      flags_d  = flags_q;
      load     = 1'b0;
`ifdef FPU_MDS_TIMEOUT_EN
      timeout_d = timeout_q;
`endif
      case (state_q)
         S_IDLE: begin
            // Reset wins over a coincident request.
            if (bus.req_valid && !reset) begin
               load = 1'b1;
`ifdef FPU_MDS_TIMEOUT_EN
               timeout_d = 1'b0;
`endif
               if (bus.req_op == 2'b11) begin
                  // Illegal op completes locally as invalid, unit untouched.
                  state_d  = S_RESP;
                  result_d = 32'h0;
                  flags_d  = 5'b10000;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE, S_BUSY: begin
            // Done takes priority over an expiring watchdog in the same cycle.
            if (bus.mds_done) begin
               state_d  = S_RESP;
               result_d = bus.mds_out;
               flags_d  = {bus.mds_invalid, bus.mds_div_by_zero,
                           bus.mds_overflow, bus.mds_underflow,
                           bus.mds_inexact};
            end
`ifdef FPU_MDS_TIMEOUT_EN
            else if (cnt_q == C_LIMIT) begin
               state_d   = S_RESP;
               result_d  = 32'h7FC0_0000;
               flags_d   = 5'b10000;
               timeout_d = 1'b1;
            end
`endif
            else begin
               state_d = S_BUSY;
            end
         end
         S_RESP: begin
            if (bus.resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         rm_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         tag_q    <= '0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         flags_q  <= flags_d;
         if (load) begin
            op_q  <= bus.req_op;
            rm_q  <= bus.req_rm;
            a_q   <= bus.req_a;
            b_q   <= bus.req_b;
            tag_q <= bus.req_tag;
         end
      end
   end

`ifdef FPU_MDS_TIMEOUT_EN
   // Counts cycles spent in ISSUE/BUSY; cleared while idle so it starts at 0
   // on entering ISSUE.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= timeout_d;
         if (state_q == S_ISSUE || state_q == S_BUSY) begin
            cnt_q <= cnt_q + 1'b1;
         end else begin
            cnt_q <= '0;
         end
      end
   end
   assign bus.resp_timeout = timeout_q;
`else
   assign bus.resp_timeout = 1'b0;
`endif

   assign bus.req_ready   = (state_q == S_IDLE) && !reset;
   assign bus.mds_start   = (state_q == S_ISSUE);
   assign bus.mds_op      = op_q;
   assign bus.mds_rm      = rm_q;
   assign bus.mds_a       = a_q;
   assign bus.mds_b       = b_q;
   assign bus.resp_valid  = (state_q == S_RESP);
   assign bus.resp_result = result_q;
   assign bus.resp_flags  = flags_q;
   assign bus.resp_tag    = tag_q;
   assign bus.busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire
